mem_stage_param: RTL and testbench
==================================

MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter DEPTH, default 128, data memory depth in XLEN-bit words (power of two, >= 2).
REQ-003 Parameter WAIT_CYCLES, default 0, extra memory-access cycles per load/store (0..15).
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-low (asserted when 0, sampled on rising clk).
REQ-006 Ports Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  input  1 each  EX/MEM control bits.
REQ-007 Port Funct3_in  input  3  access size: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 Ports Rd_in input 5; Zero_in input 1; Write_Data, ALUresult_in, PCimm_in input XLEN each  EX/MEM operands (ALUresult_in is the byte address).
REQ-009 Ports PCSrc output 1; PCimm_out output XLEN  branch decision and target.
REQ-010 Port Stall_out  output  1  upstream must hold all inputs stable while high.
REQ-011 Ports Ctl_MemtoReg_out, Ctl_RegWrite_out output 1; Rd_out output 5; Read_Data, ALUresult_out output XLEN  MEM/WB register.
REQ-012 Port Misalign_out  output  1  registered misaligned-access flag, aligned with MEM/WB outputs.

Function
REQ-013 PCSrc = Ctl_Branch_in AND Zero_in; PCimm_out = PCimm_in; both combinational, unaffected by stall.
REQ-014 Word index = ALUresult_in[log2(DEPTH)+1:2]; higher address bits ignored (addresses wrap modulo DEPTH*4 bytes).
REQ-015 Access request = MemRead OR MemWrite; both high is a read only, write suppressed.
REQ-016 Loads: byte/half lane chosen by ALUresult_in[1:0]/[1], little-endian; sign-extended for 000/001, zero-extended for 100/101; other encodings are word.
REQ-017 Stores: 000 writes one byte lane, 001 one half lane, all else full word; unselected lanes unchanged.
REQ-018 FSM states IDLE, BUSY; 4-bit counter cnt.
REQ-019 WAIT_CYCLES=0: no BUSY state ever entered; access completes in the request cycle; Stall_out constant 0.
REQ-020 WAIT_CYCLES>0, IDLE with request: Stall_out=1 (combinational), cnt<=WAIT_CYCLES-1, go BUSY.
REQ-021 BUSY, cnt!=0: Stall_out=1, cnt decrements; BUSY, cnt==0: Stall_out=0, access performed, go IDLE.
REQ-022 Total access occupancy is WAIT_CYCLES+1 cycles; memory write commits only on the completing edge.
REQ-023 Completing/non-stall edge: MEM/WB loads Rd_in, ALUresult_in, MemtoReg, RegWrite, load data (0 if not a read).
REQ-024 Stall edge: MEM/WB loads bubble (RegWrite_out=0, MemtoReg_out=0, Rd_out=0, Read_Data=0, ALUresult_out=0, Misalign_out=0).
REQ-025 Back-to-back accesses: new request in the cycle after completion starts a fresh wait sequence from IDLE.

Reset
REQ-026 On reset: state IDLE, cnt=0, all MEM/WB outputs and Misalign_out 0; memory array not cleared.
REQ-027 Reset mid-BUSY aborts the access: no memory write, Stall_out 0 in the reset cycle.

Configuration
REQ-028 Macro MEM_MISALIGN_TRAP_EN: when defined, half access with addr[0]=1 or word access with addr[1:0]!=0 suppresses the store, returns load data 0, forces RegWrite_out=0, sets Misalign_out=1 on the completing edge.
REQ-029 Without MEM_MISALIGN_TRAP_EN: low address bits ignored for alignment (lane select per REQ-016/017 only), Misalign_out tied 0.

Structure
REQ-030 Shared package holds Funct3 size encodings, FSM state typedef, and the log2 helper for the index width.
REQ-031 One sub-module mem_lane_align: combinational byte-lane write-mask generation and load extraction/extension.

Verification
REQ-032 WAIT_CYCLES=0: sw 0xDEADBEEF to addr 0xA8, then lw addr 0xA8 -> Read_Data=0xDEADBEEF next edge, Stall_out never 1.
REQ-033 WAIT_CYCLES=3: lw -> Stall_out high 3 cycles, bubbles in MEM/WB, data valid on 4th edge with RegWrite_out=1.
REQ-034 Word 0x000080FF at addr 0x10: lb 0x10 -> 0xFFFFFFFF; lbu 0x10 -> 0x000000FF; lh 0x10 -> 0xFFFF80FF; sb 0x11 of 0x12 -> word 0x000012FF.
REQ-035 DEPTH=128: sw to addr 0x200 -> lw addr 0x0 returns stored value (wrap).
REQ-036 WAIT_CYCLES=3, reset low in 2nd BUSY cycle of sw -> target word unchanged, outputs 0, state IDLE.
REQ-037 MEM_MISALIGN_TRAP_EN defined: sw to addr 0x2 -> memory unchanged, Misalign_out=1, RegWrite_out=0; undefined -> Misalign_out stays 0.

Source files
------------

// File: rtl/mem_stage_param_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// wait-state FSM states and a constant log2 helper for the word index width.
package mem_stage_param_pkg;

  // Funct3 access-size encodings
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time sizing
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_BYTE) || (f3 == F3_BYTE_U);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_HALF) || (f3 == F3_HALF_U);
  endfunction

  // Every encoding that is not a byte or half access is treated as a word
  function automatic logic is_word(input logic [2:0] f3);
    return !(is_byte(f3) || is_half(f3));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage: builds the per-byte write mask and
// the lane-replicated store data, and extracts/extends load data from the
// addressed memory word (little-endian lanes within the low 32 bits).
module mem_lane_align
  import mem_stage_param_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   mem_word,
  output logic [XLEN/8-1:0] byte_mask,
  output logic [XLEN-1:0]   store_lanes,
  output logic [XLEN-1:0]   load_data
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] byte_shifted;
  logic [XLEN-1:0] half_shifted;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;

  // Per-lane mask and store data; byte/half stores replicate the low bits
  // so whichever lane the mask enables receives the right value.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [1:0] BSEL  = 2'(gi % 4);
      localparam logic       HSEL  = 1'((gi / 2) % 2);
      localparam logic       IN_LO = (gi < 4);

      assign byte_mask[gi] = is_byte(funct3) ? (IN_LO && (addr_lo == BSEL)) :
                             is_half(funct3) ? (IN_LO && (addr_lo[1] == HSEL)) :
                                               1'b1;

      assign store_lanes[8*gi +: 8] = is_byte(funct3) ? store_data[7:0] :
                                      is_half(funct3) ? store_data[8*(gi%2) +: 8] :
                                                        store_data[8*gi +: 8];
    end
  endgenerate

  assign byte_shifted = mem_word >> {addr_lo, 3'b000};
  assign half_shifted = mem_word >> {addr_lo[1], 4'b0000};
  assign byte_val     = byte_shifted[7:0];
  assign half_val     = half_shifted[15:0];

  // Load extraction with sign or zero extension by access size
  always_comb begin
    load_data = mem_word;
    case (funct3)
      F3_BYTE:   load_data = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_BYTE_U: load_data = {{(XLEN-8){1'b0}}, byte_val};
      F3_HALF:   load_data = {{(XLEN-16){half_val[15]}}, half_val};
      F3_HALF_U: load_data = {{(XLEN-16){1'b0}}, half_val};
      default:   load_data = mem_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_param.sv
// MEM pipeline stage with data memory, optional wait states and MEM/WB
// register. Branch decision is combinational pass-through. When
// MEM_MISALIGN_TRAP_EN is defined, misaligned half/word accesses are
// suppressed and flagged on Misalign_out; otherwise low address bits only
// select lanes and Misalign_out stays 0.
module mem_stage_param
  import mem_stage_param_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Ctl_MemtoReg_in,
  input  logic            Ctl_RegWrite_in,
  input  logic            Ctl_MemRead_in,
  input  logic            Ctl_MemWrite_in,
  input  logic            Ctl_Branch_in,
  input  logic [2:0]      Funct3_in,
  input  logic [4:0]      Rd_in,
  input  logic            Zero_in,
  input  logic [XLEN-1:0] Write_Data,
  input  logic [XLEN-1:0] ALUresult_in,
  input  logic [XLEN-1:0] PCimm_in,
  output logic            PCSrc,
  output logic [XLEN-1:0] PCimm_out,
  output logic            Stall_out,
  output logic            Ctl_MemtoReg_out,
  output logic            Ctl_RegWrite_out,
  output logic [4:0]      Rd_out,
  output logic [XLEN-1:0] Read_Data,
  output logic [XLEN-1:0] ALUresult_out,
  output logic            Misalign_out
);

  localparam int         IDXW   = clog2_f(DEPTH);
  localparam int         NB     = XLEN / 8;
  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [XLEN-1:0] mem [DEPTH];

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [IDXW-1:0] word_idx;
  logic [XLEN-1:0] mem_word;
  logic [NB-1:0]   byte_mask;
  logic [XLEN-1:0] store_lanes;
  logic [XLEN-1:0] load_data;
  logic            access_req;
  logic            misalign;
  logic            stall;
  logic            wr_en;

  logic            memtoreg_reg;
  logic            regwrite_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] read_data_reg;
  logic [XLEN-1:0] alu_reg;
  logic            misalign_reg;

  logic            unused_addr_bits;

  assign PCSrc     = Ctl_Branch_in & Zero_in;
  assign PCimm_out = PCimm_in;

  assign word_idx         = ALUresult_in[IDXW+1:2];
  assign unused_addr_bits = ^ALUresult_in[XLEN-1:IDXW+2];
  assign access_req       = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign mem_word         = mem[word_idx];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access_req &
                    ((is_half(Funct3_in) & ALUresult_in[0]) |
                     (is_word(Funct3_in) & (ALUresult_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .funct3      (Funct3_in),
    .addr_lo     (ALUresult_in[1:0]),
    .store_data  (Write_Data),
    .mem_word    (mem_word),
    .byte_mask   (byte_mask),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  // Stall while a wait sequence is pending; reset releases it immediately
  always_comb begin
    stall = 1'b0;
    if ((WAIT_CYCLES != 0) && reset) begin
      if (state_reg == IDLE) stall = access_req;
      else                   stall = (cnt_reg != 4'd0);
    end
  end

  assign Stall_out = stall;
  // A read wins over a simultaneous write; writes land only on the completing edge
  assign wr_en = reset & ~stall & Ctl_MemWrite_in & ~Ctl_MemRead_in & ~misalign;

  // Wait-state FSM: IDLE -> BUSY with cnt preloaded, count down to completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else if (WAIT_CYCLES != 0) begin
      case (state_reg)
        IDLE: begin
          if (access_req) begin
            state_reg <= BUSY;
            cnt_reg   <= WAIT_M1;
          end
        end
        BUSY: begin
          if (cnt_reg == 4'd0) state_reg <= IDLE;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Byte-masked store into the data memory (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_mask[b]) mem[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

  // MEM/WB register: bubble on stall edges, result on completing edges
  always_ff @(posedge clk) begin
    if (!reset || stall) begin
      memtoreg_reg  <= 1'b0;
      regwrite_reg  <= 1'b0;
      rd_reg        <= 5'd0;
      read_data_reg <= '0;
      alu_reg       <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      memtoreg_reg  <= Ctl_MemtoReg_in;
      regwrite_reg  <= Ctl_RegWrite_in & ~misalign;
      rd_reg        <= Rd_in;
      read_data_reg <= (Ctl_MemRead_in & ~misalign) ? load_data : '0;
      alu_reg       <= ALUresult_in;
      misalign_reg  <= misalign;
    end
  end

  assign Ctl_MemtoReg_out = memtoreg_reg;
  assign Ctl_RegWrite_out = regwrite_reg;
  assign Rd_out           = rd_reg;
  assign Read_Data        = read_data_reg;
  assign ALUresult_out    = alu_reg;
  assign Misalign_out     = misalign_reg;

endmodule

// File: tb/tb_mem_stage_param.sv
// Scoreboard bench for mem_stage_param: dut0 has no wait states, dut1 has
// three. The driver pushes expected MEM/WB contents; a monitor pops and
// compares whenever a DUT presents RegWrite_out or Misalign_out.
module tb_mem_stage_param;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic        mt;
    logic        rw;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        mt_in [2], rw_in [2], rd_en [2], wr_en [2], br [2], zero [2];
  logic [2:0]  f3 [2];
  logic [4:0]  rd_in [2];
  logic [31:0] wdata [2], addr [2], pcimm [2];

  logic        pcsrc [2], stall [2], mt_o [2], rw_o [2], mis_o [2];
  logic [4:0]  rd_o [2];
  logic [31:0] pcimm_o [2], rdata_o [2], alu_o [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  mem_stage_param #(.XLEN(32), .DEPTH(128), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n[0]),
    .Ctl_MemtoReg_in(mt_in[0]), .Ctl_RegWrite_in(rw_in[0]),
    .Ctl_MemRead_in(rd_en[0]), .Ctl_MemWrite_in(wr_en[0]), .Ctl_Branch_in(br[0]),
    .Funct3_in(f3[0]), .Rd_in(rd_in[0]), .Zero_in(zero[0]),
    .Write_Data(wdata[0]), .ALUresult_in(addr[0]), .PCimm_in(pcimm[0]),
    .PCSrc(pcsrc[0]), .PCimm_out(pcimm_o[0]), .Stall_out(stall[0]),
    .Ctl_MemtoReg_out(mt_o[0]), .Ctl_RegWrite_out(rw_o[0]), .Rd_out(rd_o[0]),
    .Read_Data(rdata_o[0]), .ALUresult_out(alu_o[0]), .Misalign_out(mis_o[0])
  );

  mem_stage_param #(.XLEN(32), .DEPTH(128), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst_n[1]),
    .Ctl_MemtoReg_in(mt_in[1]), .Ctl_RegWrite_in(rw_in[1]),
    .Ctl_MemRead_in(rd_en[1]), .Ctl_MemWrite_in(wr_en[1]), .Ctl_Branch_in(br[1]),
    .Funct3_in(f3[1]), .Rd_in(rd_in[1]), .Zero_in(zero[1]),
    .Write_Data(wdata[1]), .ALUresult_in(addr[1]), .PCimm_in(pcimm[1]),
    .PCSrc(pcsrc[1]), .PCimm_out(pcimm_o[1]), .Stall_out(stall[1]),
    .Ctl_MemtoReg_out(mt_o[1]), .Ctl_RegWrite_out(rw_o[1]), .Rd_out(rd_o[1]),
    .Read_Data(rdata_o[1]), .ALUresult_out(alu_o[1]), .Misalign_out(mis_o[1])
  );

  task automatic idle(input int d);
    rd_en[d] = 1'b0; wr_en[d] = 1'b0; rw_in[d] = 1'b0; mt_in[d] = 1'b0;
    br[d] = 1'b0; zero[d] = 1'b0; f3[d] = 3'b000; rd_in[d] = 5'd0;
    addr[d] = 32'd0; wdata[d] = 32'd0; pcimm[d] = 32'd0;
  endtask

  // MEM/WB outputs all zero and no stall
  task automatic check_zero(input int d, input string name);
    checks++;
    if (stall[d] || mt_o[d] || rw_o[d] || mis_o[d] || rd_o[d] != 5'd0 ||
        rdata_o[d] != 32'd0 || alu_o[d] != 32'd0) begin
      errors++;
      $display("FAIL %s dut%0d: stall=%0b rw=%0b mt=%0b mis=%0b rd=%0d data=%h alu=%h, required all 0",
               name, d, stall[d], rw_o[d], mt_o[d], mis_o[d], rd_o[d], rdata_o[d], alu_o[d]);
    end
  endtask

  // Issue one access, hold it through the stall, then release
  task automatic xact(input int d, input string name, input logic r, input logic w,
                      input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_mis);
    exp_t e;
    int   n;
    int   exp_stall;
    bit   timed_out;
    e.rd = rd; e.alu = a; e.data = exp_data; e.mt = r; e.rw = ~exp_mis; e.mis = exp_mis;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    exp_stall = (d == 1 && (r || w)) ? 3 : 0;
    rd_en[d] = r; wr_en[d] = w; f3[d] = fn; addr[d] = a; wdata[d] = wd;
    rd_in[d] = rd; rw_in[d] = 1'b1; mt_in[d] = r;
    n = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!stall[d]) break;
      n++;
      if (n > 20) begin timed_out = 1'b1; break; end
    end
    @(posedge clk); #1;
    idle(d);
    checks++;
    if (timed_out || n != exp_stall) begin
      errors++;
      $display("FAIL stall_%s dut%0d: stall cycles %0d, required %0d", name, d, n, exp_stall);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (rw_o[d] || mis_o[d]) begin
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        e = '0;
        if (have) e = (d == 0) ? q0.pop_front() : q1.pop_front();
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_output dut%0d: rd=%0d data=%h, required no output", d, rd_o[d], rdata_o[d]);
        end else if (rd_o[d] != e.rd || alu_o[d] != e.alu || rdata_o[d] != e.data ||
                     mt_o[d] != e.mt || rw_o[d] != e.rw || mis_o[d] != e.mis) begin
          errors++;
          $display("FAIL memwb dut%0d: rd=%0d alu=%h data=%h mt=%0b rw=%0b mis=%0b, required rd=%0d alu=%h data=%h mt=%0b rw=%0b mis=%0b",
                   d, rd_o[d], alu_o[d], rdata_o[d], mt_o[d], rw_o[d], mis_o[d],
                   e.rd, e.alu, e.data, e.mt, e.rw, e.mis);
        end else begin
          $display("dut%0d rd=%0d alu=%h data=%h mis=%0b ok", d, rd_o[d], alu_o[d], rdata_o[d], mis_o[d]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle(d);
      rst_n[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Branch decision is combinational
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        br[d] = i[0]; zero[d] = i[1]; pcimm[d] = 32'h1000_0000 + 32'(i * 4);
        #1;
        checks++;
        if (pcsrc[d] != (i == 3) || pcimm_o[d] != 32'h1000_0000 + 32'(i * 4)) begin
          errors++;
          $display("FAIL pcsrc dut%0d case %0d: pcsrc=%0b pcimm=%h, required pcsrc=%0b pcimm=%h",
                   d, i, pcsrc[d], pcimm_o[d], (i == 3), 32'h1000_0000 + 32'(i * 4));
        end
      end
      idle(d);
    end
    @(posedge clk); #1;

    // Zero-wait unit
    xact(0, "sw_a8",   1'b0, 1'b1, LW,  32'hA8, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0);
    xact(0, "lw_a8",   1'b1, 1'b0, LW,  32'hA8, 32'h0,        5'd2, 32'hDEADBEEF, 1'b0);
    xact(0, "sw_10",   1'b0, 1'b1, LW,  32'h10, 32'h000080FF, 5'd3, 32'h0, 1'b0);
    xact(0, "lb_10",   1'b1, 1'b0, LB,  32'h10, 32'h0,        5'd4, 32'hFFFFFFFF, 1'b0);
    xact(0, "lbu_10",  1'b1, 1'b0, LBU, 32'h10, 32'h0,        5'd5, 32'h000000FF, 1'b0);
    xact(0, "lh_10",   1'b1, 1'b0, LH,  32'h10, 32'h0,        5'd6, 32'hFFFF80FF, 1'b0);
    xact(0, "lhu_10",  1'b1, 1'b0, LHU, 32'h10, 32'h0,        5'd7, 32'h000080FF, 1'b0);
    xact(0, "sb_11",   1'b0, 1'b1, LB,  32'h11, 32'hABCDEF12, 5'd8, 32'h0, 1'b0);
    xact(0, "lw_10",   1'b1, 1'b0, LW,  32'h10, 32'h0,        5'd9, 32'h000012FF, 1'b0);
    xact(0, "lb_11",   1'b1, 1'b0, LB,  32'h11, 32'h0,        5'd10, 32'h00000012, 1'b0);
    xact(0, "sh_12",   1'b0, 1'b1, LH,  32'h12, 32'h7777BEEF, 5'd11, 32'h0, 1'b0);
    xact(0, "lw_10b",  1'b1, 1'b0, LW,  32'h10, 32'h0,        5'd12, 32'hBEEF12FF, 1'b0);
    xact(0, "lh_12",   1'b1, 1'b0, LH,  32'h12, 32'h0,        5'd13, 32'hFFFFBEEF, 1'b0);
    xact(0, "lbu_13",  1'b1, 1'b0, LBU, 32'h13, 32'h0,        5'd14, 32'h000000BE, 1'b0);
    xact(0, "rw_both", 1'b1, 1'b1, LW,  32'h10, 32'h55555555, 5'd15, 32'hBEEF12FF, 1'b0);
    xact(0, "lw_10c",  1'b1, 1'b0, LW,  32'h10, 32'h0,        5'd16, 32'hBEEF12FF, 1'b0);
    xact(0, "sw_200",  1'b0, 1'b1, LW,  32'h200, 32'hCAFEF00D, 5'd17, 32'h0, 1'b0);
    xact(0, "lw_0",    1'b1, 1'b0, LW,  32'h0,  32'h0,        5'd18, 32'hCAFEF00D, 1'b0);
    xact(0, "alu_op",  1'b0, 1'b0, LW,  32'h12345678, 32'h0,  5'd19, 32'h0, 1'b0);
    xact(0, "sw_20",   1'b0, 1'b1, LW,  32'h20, 32'h11223344, 5'd20, 32'h0, 1'b0);
    xact(0, "sw_22",   1'b0, 1'b1, LW,  32'h22, 32'hAABBCCDD, 5'd21, 32'h0, TRAP);
    xact(0, "lw_20",   1'b1, 1'b0, LW,  32'h20, 32'h0,        5'd22,
         TRAP ? 32'h11223344 : 32'hAABBCCDD, 1'b0);

    // Three-wait unit
    xact(1, "sw_40",   1'b0, 1'b1, LW,  32'h40, 32'h01020304, 5'd1, 32'h0, 1'b0);
    xact(1, "lw_40",   1'b1, 1'b0, LW,  32'h40, 32'h0,        5'd2, 32'h01020304, 1'b0);
    xact(1, "lbu_43",  1'b1, 1'b0, LBU, 32'h43, 32'h0,        5'd3, 32'h00000001, 1'b0);
    xact(1, "alu_op",  1'b0, 1'b0, LW,  32'hCAFE0000, 32'h0,  5'd4, 32'h0, 1'b0);

    // Reset during the second BUSY cycle of a store aborts it
    rd_en[1] = 1'b0; wr_en[1] = 1'b1; f3[1] = LW; addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if (stall[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_reset dut1: stall=%0b, required 0", stall[1]);
    end
    @(posedge clk); #1;
    idle(1);
    rst_n[1] = 1'b1;
    check_zero(1, "abort_reset");
    xact(1, "lw_40_after_abort", 1'b1, 1'b0, LW, 32'h40, 32'h0, 5'd5, 32'h01020304, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
